// File: rtl/pwm_pkg.sv
// Shared constants, FSM state type and duty-to-sample conversion for the PWM
// generator / demodulator pair.
package pwm_pkg;

  localparam int unsigned BIT_WIDTH_DEF = 8;
  localparam int unsigned PWM_FREQ_DEF  = 1000;
  localparam int unsigned SYS_FREQ_DEF  = 50_000_000;

  localparam int unsigned CLK_COUNTS_PWM_PERIOD = SYS_FREQ_DEF / PWM_FREQ_DEF;
  localparam int unsigned CLK_COUNTS_PWM_RES    = CLK_COUNTS_PWM_PERIOD / (1 << BIT_WIDTH_DEF);
  localparam int unsigned SAMPLE_WIDTH          = 24;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } demod_state_e;

  // Centre the duty word around zero and scale it to full sample width.
  // The difference is formed at 32 bits, so it is already sign-extended.
  function automatic logic signed [SAMPLE_WIDTH-1:0] duty_to_sample(
    input logic [15:0] duty,
    input int unsigned bit_width
  );
    logic signed [31:0] diff;
    logic signed [31:0] shifted;
    diff    = $signed({16'd0, duty}) - (32'sd1 <<< (bit_width - 1));
    shifted = diff <<< (SAMPLE_WIDTH - bit_width);
    return shifted[SAMPLE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pwm_duty_demodulator_if.sv
// Result bundle of the duty demodulator: one measured period per sample_valid pulse.
interface pwm_duty_demodulator_if
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) ();

  // Handshake: sample_valid is a one-cycle pulse with no ready/backpressure;
  // duty, q_sample, period_err and stuck change only on that pulse and hold
  // their value in between, so the consumer must take every pulse it sees.
  logic [BIT_WIDTH-1:0]           duty;
  logic signed [SAMPLE_WIDTH-1:0] q_sample;
  logic                           sample_valid;
  logic                           period_err;
  logic                           stuck;
  demod_state_e                   dbg_state;

  modport master (
    output duty,
    output q_sample,
    output sample_valid,
    output period_err,
    output stuck,
    output dbg_state
  );

  modport slave (
    input duty,
    input q_sample,
    input sample_valid,
    input period_err,
    input stuck,
    input dbg_state
  );

endinterface

// File: rtl/pwm_input_sync.sv
// Brings the asynchronous PWM pin into the clk domain and detects rising edges.
module pwm_input_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  // rise is registered, and level is taken from the previous-level flop, so
  // both leave this block on the same cycle and stay aligned with each other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/pwm_duty_demodulator.sv
// Measures the duty cycle of an external PWM waveform in generator ticks and
// emits a duty word plus a centred signed sample once per period.
module pwm_duty_demodulator
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int PWM_FREQ  = 1000,
  parameter int SYS_FREQ  = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pwm_in,
  pwm_duty_demodulator_if.master  out_if
);

  localparam int RES  = SYS_FREQ / PWM_FREQ / (2 ** BIT_WIDTH);
  localparam int PS_W = (RES > 1) ? $clog2(RES) : 1;
  localparam int HT_W = BIT_WIDTH + 1;
  localparam int PT_W = BIT_WIDTH + 2;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(RES - 1);
  localparam logic [PT_W-1:0] TIMEOUT = PT_W'(2 ** (BIT_WIDTH + 1));
  localparam logic [PT_W-1:0] PER_MIN = PT_W'(2 ** BIT_WIDTH - 2);
  localparam logic [PT_W-1:0] PER_MAX = PT_W'(2 ** BIT_WIDTH + 1);

  logic level;
  logic rise;

  pwm_input_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pwm_i   (pwm_in),
    .level_o (level),
    .rise_o  (rise)
  );

  demod_state_e                   state_q, state_d;
  logic [PS_W-1:0]                prescaler_q, prescaler_d;
  logic [HT_W-1:0]                high_q, high_d;
  logic [PT_W-1:0]                period_q, period_d;
  logic [BIT_WIDTH-1:0]           duty_q, duty_d;
  logic signed [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                           valid_q, valid_d;
  logic                           err_q, err_d;
  logic                           stuck_q, stuck_d;

  logic                           tick;
  logic                           timeout;
  logic [HT_W-1:0]                high_cnt;
  logic [PT_W-1:0]                period_cnt;
  logic [BIT_WIDTH-1:0]           high_clamped;

  assign tick = (prescaler_q == PS_LAST);

  // Restarting the prescaler on each rise keeps tick boundaries phase-locked
  // to the incoming waveform rather than to an arbitrary free-running count.
  always_comb begin
    prescaler_d = prescaler_q + 1'b1;
    if (rise || tick) begin
      prescaler_d = '0;
    end
  end

  // Counts including this cycle's tick, so a tick coinciding with a rise is
  // credited to the measurement that the rise closes.
  always_comb begin
    high_cnt = high_q;
    if (tick && level && (high_q != '1)) begin
      high_cnt = high_q + 1'b1;
    end
    period_cnt = period_q;
    if (tick && (period_q != '1)) begin
      period_cnt = period_q + 1'b1;
    end
  end

  assign high_clamped = high_cnt[BIT_WIDTH] ? '1 : high_cnt[BIT_WIDTH-1:0];
  assign timeout      = (period_cnt == TIMEOUT) && !rise;

  always_comb begin
    state_d  = state_q;
    high_d   = high_cnt;
    period_d = period_cnt;
    duty_d   = duty_q;
    err_d    = err_q;
    stuck_d  = stuck_q;
    valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The period in progress when we leave IDLE is partial; discard it.
        if (rise) begin
          high_d   = '0;
          period_d = '0;
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          duty_d   = high_clamped;
          err_d    = (period_cnt < PER_MIN) || (period_cnt > PER_MAX);
          stuck_d  = 1'b0;
          valid_d  = 1'b1;
          high_d   = '0;
          period_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // No edge for two nominal periods: report the held level as 0 % or 100 %.
    if (timeout) begin
      duty_d   = level ? '1 : '0;
      stuck_d  = 1'b1;
      valid_d  = 1'b1;
      high_d   = '0;
      period_d = '0;
      state_d  = IDLE;
    end

    sample_d = duty_to_sample(16'(duty_d), BIT_WIDTH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      high_q      <= '0;
      period_q    <= '0;
      duty_q      <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      high_q      <= high_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      stuck_q     <= stuck_d;
    end
  end

  assign out_if.duty         = duty_q;
  assign out_if.q_sample     = sample_q;
  assign out_if.sample_valid = valid_q;
  assign out_if.period_err   = err_q;
  assign out_if.stuck        = stuck_q;
  assign out_if.dbg_state    = state_q;

endmodule

// File: tb/tb_pwm_duty_demodulator.sv
// Directed bench for pwm_duty_demodulator, scaled to 768 clocks per PWM period
// (3 clocks per tick) so that stuck-input timeouts fit in a short run.
module tb_pwm_duty_demodulator;
  import pwm_pkg::*;

  localparam int BW = 8;
  localparam int EW = 34;  // {stuck, period_err, q_sample[23:0], duty[7:0]}

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic pwm_in  = 1'b0;

  pwm_duty_demodulator_if #(.BIT_WIDTH(BW)) ifc ();

  pwm_duty_demodulator #(
    .BIT_WIDTH (BW),
    .PWM_FREQ  (1000),
    .SYS_FREQ  (768000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pwm_in  (pwm_in),
    .out_if  (ifc)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] prev_exp;
  logic [EW-1:0] mon_e;
  bit            have_prev = 1'b0;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [EW-1:0] mk_exp(input int duty, input int q, input bit err, input bit stk);
    logic [23:0] q24;
    logic [7:0]  d8;
    q24 = q[23:0];
    d8  = duty[7:0];
    return {stk, err, q24, d8};
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_duty"},   int'(ifc.duty), 0);
    check({tag, "_q"},      int'(ifc.q_sample), 0);
    check({tag, "_valid"},  int'(ifc.sample_valid), 0);
    check({tag, "_err"},    int'(ifc.period_err), 0);
    check({tag, "_stuck"},  int'(ifc.stuck), 0);
  endtask

  // One full period starting with a rise; that rise closes the previous period.
  task automatic drive_period(input int h, input int l, input logic [EW-1:0] e);
    if (have_prev) exp_q.push_back(prev_exp);
    prev_exp  = e;
    have_prev = 1'b1;
    pwm_in = 1'b1;
    wait_clks(h);
    pwm_in = 1'b0;
    wait_clks(l);
  endtask

  // A period long enough to time out; the timeout sample is expected next.
  task automatic stuck_period(input int h, input int l, input logic [EW-1:0] e_timeout);
    if (have_prev) exp_q.push_back(prev_exp);
    exp_q.push_back(e_timeout);
    have_prev = 1'b0;
    pwm_in = 1'b1;
    wait_clks(h);
    pwm_in = 1'b0;
    wait_clks(l);
  endtask

  always @(negedge clk) begin
    if (reset_n && ifc.sample_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got duty %0d with no expected sample at %0t", ifc.duty, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("duty",       int'(ifc.duty),         int'(mon_e[7:0]));
        check("q_sample",   int'(ifc.q_sample),     int'($signed(mon_e[31:8])));
        check("period_err", int'(ifc.period_err),   int'(mon_e[32]));
        check("stuck",      int'(ifc.stuck),        int'(mon_e[33]));
      end
    end
  end

  initial begin
    int budget;

    // Reset held while the pin toggles: nothing may come out.
    for (int i = 0; i < 12; i++) begin
      pwm_in = ~pwm_in;
      wait_clks(2 + i % 3);
    end
    pwm_in = 1'b0;
    wait_clks(2);
    check_outputs_zero("rst");
    reset_n = 1'b1;
    wait_clks(20);

    // 25 %: 192 high of 768 -> 63 ticks + the tick on the closing rise = 64
    repeat (3) drive_period(192, 576, mk_exp(64, -4194304, 1'b0, 1'b0));
    repeat (2) drive_period(384, 384, mk_exp(128, 0, 1'b0, 1'b0));
    // 100 % minus one tick
    repeat (2) drive_period(765, 3, mk_exp(255, 8323072, 1'b0, 1'b0));
    // 900 Hz equivalent: 852 clocks = 284 ticks, 426 high -> 142
    repeat (2) drive_period(426, 426, mk_exp(142, 917504, 1'b1, 1'b0));
    repeat (2) drive_period(384, 384, mk_exp(128, 0, 1'b0, 1'b0));

    // Held high past 512 ticks (1536 clocks): stuck, duty full scale
    stuck_period(1900, 384, mk_exp(255, 8323072, 1'b0, 1'b1));
    repeat (2) drive_period(384, 384, mk_exp(128, 0, 1'b0, 1'b0));

    // Asynchronous reset in the middle of a high phase
    if (have_prev) exp_q.push_back(prev_exp);
    have_prev = 1'b0;
    pwm_in = 1'b1;
    wait_clks(100);
    #3 reset_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    wait_clks(5);
    pwm_in = 1'b0;
    wait_clks(20);
    reset_n = 1'b1;
    wait_clks(50);

    repeat (2) drive_period(384, 384, mk_exp(128, 0, 1'b0, 1'b0));
    // Input then stays low: stuck with duty 0
    stuck_period(384, 1400, mk_exp(0, -8388608, 1'b0, 1'b1));

    budget = 4000;
    while (exp_q.size() != 0 && budget > 0) begin
      wait_clks(1);
      budget--;
    end
    wait_clks(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_samples: got %0d outstanding expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
